alu_serial_seq: RTL and testbench
=================================

# alu_serial_seq

Bit-serial sequencer that computes a WIDTH-bit ALU operation by driving a single one-bit `alu1` slice for WIDTH consecutive cycles, LSB first, threading the carry between cycles through a register. It sits between the calculator's command logic and the one-bit ALU datapath, trading latency for area. It also exposes a start/busy/done handshake and produces result, carry-out, overflow and zero flags.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥2)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers
- start  in  1  request; sampled only when `busy`=0
- A  in  WIDTH  operand A, latched on accepted start
- B  in  WIDTH  operand B, latched on accepted start
- control  in  3  ALU op code (ALU_ADD=2, ALU_SUB=3, ALU_AND=4, ALU_OR=5, ALU_NOR=6, ALU_XOR=7), latched on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when result is valid
- out  out  WIDTH  result; held stable from `done` until next accepted start
- carryout  out  1  carry out of MSB slice (arithmetic ops), else 0
- overflow  out  1  signed overflow (arithmetic ops), else 0
- zero  out  1  1 when `out`==0

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1: latch A, B, control; bit index ← 0; carry register ← control[0] if control[2]==0, else 0; result shift register cleared; next state RUN.
- IDLE + start=0: stay. DONE + start=0: → IDLE.
- RUN, each cycle: feed A[idx], B[idx], carry register and latched control to the `alu1` slice; write slice `out` into result bit idx; carry register ← slice carryout; idx ← idx+1.
- RUN at idx==WIDTH-1: also capture carry-in of this slice (for overflow) and slice carryout; → DONE.
- In DONE: `done`=1; `out` = full result; carryout = MSB carry-out if control[2]==0 else 0; overflow = (carry into MSB) XOR (carry out of MSB) if control[2]==0 else 0; zero = (out==0).
- start while busy=1 is ignored; operands and control are not re-latched.
- Codes 0/1 are not rejected: they decode exactly as the slice decodes them (adder path, B inverted per control[0]).
- Index counter is $clog2(WIDTH) bits; no wrap within an operation (leaves RUN at WIDTH-1).

## Timing
- Reset values: busy=0, done=0, out=0, carryout=0, overflow=0, zero=1 (out==0), state=IDLE, idx=0, carry=0.
- Reset asserted mid-RUN: immediate abort, reset values, no `done`.
- Latency: start accepted at edge N → busy=1 cycles N+1..N+WIDTH → done=1 in cycle N+WIDTH+1.
- Back-to-back: start high during the DONE cycle is accepted; the next RUN begins with no IDLE bubble. Throughput is one op per WIDTH+1 cycles.
- `out` and flags are registered; they change only at the end of RUN (visible with `done`) and are cleared only by reset. Starting a new op leaves the previous result visible until its `done`.
- `zero` is derived combinationally from the registered `out`.

## Structure
- Shared package/include: ALU op-code constants (ALU_ADD..ALU_XOR), state encoding for IDLE/RUN/DONE, arithmetic predicate (control[2]==0).
- One sub-module: reuse the existing `alu1` bit slice, instantiated once. No new sub-module. Sequencer (FSM, idx counter, carry register, operand/result shift registers) lives in this block.

## Test plan
- ADD 0x00000005+0x00000003, start one cycle → busy 32 cycles, done at cycle 33, out=0x00000008, carryout=0, overflow=0, zero=0.
- SUB 0x80000000−0x00000001 → out=0x7FFFFFFF, carryout=1, overflow=1; SUB 7−7 → out=0, zero=1, carryout=1, overflow=0.
- ADD 0xFFFFFFFF+0x00000001 → out=0, carryout=1, overflow=0, zero=1.
- Logic ops on A=0xF0F0F0F0, B=0xFF00FF00: AND→0xF000F000, OR→0xFFF0FFF0, NOR→0x000F000F, XOR→0x0FF00FF0; carryout=0, overflow=0 for all.
- start toggled during RUN with different A/B → ignored; result matches first op. Start held high in DONE → second op begins with no bubble, second done 33 cycles later.
- reset pulse at RUN cycle 10 → busy=0, done never asserted, out=0; following ADD 1+1 → out=2.

Source files
------------

// File: rtl/alu_serial_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer and its one-bit slice.
package alu_serial_seq_pkg;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Codes with control[2]==0 (including the unnamed 0/1) take the adder path.
  function automatic logic is_arith(input logic [2:0] ctrl);
    return ~ctrl[2];
  endfunction

endpackage

// File: rtl/alu1.sv
// One-bit ALU slice: adder path with optional B inversion, plus AND/OR/NOR/XOR.
module alu1
  import alu_serial_seq_pkg::*;
(
  input  logic       A,
  input  logic       B,
  input  logic       carryin,
  input  logic [2:0] control,
  output logic       out,
  output logic       carryout
);

  logic w_b_eff;
  logic w_sum;

  assign w_b_eff  = B ^ control[0];
  assign w_sum    = A ^ w_b_eff ^ carryin;
  assign carryout = (A & w_b_eff) | (A & carryin) | (w_b_eff & carryin);

  // Select the slice result; anything not a logic op goes through the adder.
  always_comb begin
    out = w_sum;
    case (control)
      ALU_AND: out = A & B;
      ALU_OR:  out = A | B;
      ALU_NOR: out = ~(A | B);
      ALU_XOR: out = A ^ B;
      default: out = w_sum;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: drives one alu1 slice for WIDTH cycles, LSB first,
// threading the carry through a register; start/busy/done handshake.
module alu_serial_seq
  import alu_serial_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_out;
  logic [2:0]         r_ctrl;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic               w_slice_out;
  logic               w_slice_cout;
  logic               w_last;
  logic               w_accept;

  assign w_last   = (r_idx == LAST_IDX);
  assign w_accept = start && (r_state != ST_RUN);

  alu1 u_alu1 (
    .A        (r_a[0]),
    .B        (r_b[0]),
    .carryin  (r_carry),
    .control  (r_ctrl),
    .out      (w_slice_out),
    .carryout (w_slice_cout)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; DONE accepts a new start directly for back-to-back ops.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = start ? ST_RUN : ST_IDLE;
      ST_RUN:  w_next = w_last ? ST_DONE : ST_RUN;
      ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operands shift right so bit idx is always at position 0, and the
  // result fills from the top so after WIDTH shifts bit 0 lands at LSB.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_out   <= '0;
      r_ctrl  <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_ctrl  <= control;
      r_idx   <= '0;
      r_carry <= is_arith(control) ? control[0] : 1'b0;
      r_res   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= {w_slice_out, r_res[WIDTH-1:1]};
      r_carry <= w_slice_cout;
      if (w_last) begin
        // r_carry here is the carry into the MSB slice.
        r_out  <= {w_slice_out, r_res[WIDTH-1:1]};
        r_cout <= is_arith(r_ctrl) & w_slice_cout;
        r_ovf  <= is_arith(r_ctrl) & (r_carry ^ w_slice_cout);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign out      = r_out;
  assign carryout = r_cout;
  assign overflow = r_ovf;
  assign zero     = (r_out == '0);

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq (WIDTH=32).
module tb_alu_serial_seq;
  import alu_serial_seq_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   control;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         carryout;
  logic         overflow;
  logic         zero;

  int total = 0;
  int bad   = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .control  (control),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .carryout (carryout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clock = ~clock;

  // Stimulus only: one-cycle start, then wait (bounded) for done at a negedge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                        output int lat, output int busy_cnt);
    @(negedge clock);
    A = a; B = b; control = c; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; A = '0; B = '0; control = '0;
    repeat (2) @(negedge clock);
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (out !== '0)        begin bad++; $display("FAIL reset_out got=%h exp=0", out); end
    total++; if (carryout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%0b exp=0", carryout); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
    total++; if (zero !== 1'b1)     begin bad++; $display("FAIL reset_zero got=%0b exp=1", zero); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    int lat, bc;
    run_op(32'h5, 32'h3, ALU_ADD, lat, bc);
    total++; if (lat != 33)         begin bad++; $display("FAIL add_latency got=%0d exp=33", lat); end
    total++; if (bc != 32)          begin bad++; $display("FAIL add_busy_cycles got=%0d exp=32", bc); end
    total++; if (out !== 32'h8)     begin bad++; $display("FAIL add_out got=%h exp=00000008", out); end
    total++; if (carryout !== 1'b0) begin bad++; $display("FAIL add_cout got=%0b exp=0", carryout); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL add_ovf got=%0b exp=0", overflow); end
    total++; if (zero !== 1'b0)     begin bad++; $display("FAIL add_zero got=%0b exp=0", zero); end
    @(negedge clock);
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL add_done_pulse got=%0b exp=0", done); end
    total++; if (out !== 32'h8)     begin bad++; $display("FAIL add_out_hold got=%h exp=00000008", out); end
  endtask

  task automatic test_sub();
    int lat, bc;
    run_op(32'h8000_0000, 32'h1, ALU_SUB, lat, bc);
    total++; if (lat != 33)            begin bad++; $display("FAIL sub1_latency got=%0d exp=33", lat); end
    total++; if (out !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sub1_out got=%h exp=7fffffff", out); end
    total++; if (carryout !== 1'b1)    begin bad++; $display("FAIL sub1_cout got=%0b exp=1", carryout); end
    total++; if (overflow !== 1'b1)    begin bad++; $display("FAIL sub1_ovf got=%0b exp=1", overflow); end
    run_op(32'h7, 32'h7, ALU_SUB, lat, bc);
    total++; if (lat != 33)            begin bad++; $display("FAIL sub2_latency got=%0d exp=33", lat); end
    total++; if (out !== '0)           begin bad++; $display("FAIL sub2_out got=%h exp=0", out); end
    total++; if (zero !== 1'b1)        begin bad++; $display("FAIL sub2_zero got=%0b exp=1", zero); end
    total++; if (carryout !== 1'b1)    begin bad++; $display("FAIL sub2_cout got=%0b exp=1", carryout); end
    total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL sub2_ovf got=%0b exp=0", overflow); end
  endtask

  task automatic test_add_wrap();
    int lat, bc;
    run_op(32'hFFFF_FFFF, 32'h1, ALU_ADD, lat, bc);
    total++; if (lat != 33)         begin bad++; $display("FAIL wrap_latency got=%0d exp=33", lat); end
    total++; if (out !== '0)        begin bad++; $display("FAIL wrap_out got=%h exp=0", out); end
    total++; if (carryout !== 1'b1) begin bad++; $display("FAIL wrap_cout got=%0b exp=1", carryout); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%0b exp=0", overflow); end
    total++; if (zero !== 1'b1)     begin bad++; $display("FAIL wrap_zero got=%0b exp=1", zero); end
  endtask

  task automatic test_logic();
    logic [2:0]   ops [4];
    logic [W-1:0] exps[4];
    int lat, bc;
    ops[0] = ALU_AND; exps[0] = 32'hF000_F000;
    ops[1] = ALU_OR;  exps[1] = 32'hFFF0_FFF0;
    ops[2] = ALU_NOR; exps[2] = 32'h000F_000F;
    ops[3] = ALU_XOR; exps[3] = 32'h0FF0_0FF0;
    for (int i = 0; i < 4; i++) begin
      run_op(32'hF0F0_F0F0, 32'hFF00_FF00, ops[i], lat, bc);
      total++; if (lat != 33)         begin bad++; $display("FAIL logic%0d_latency got=%0d exp=33", i, lat); end
      total++; if (out !== exps[i])   begin bad++; $display("FAIL logic%0d_out got=%h exp=%h", i, out, exps[i]); end
      total++; if (carryout !== 1'b0) begin bad++; $display("FAIL logic%0d_cout got=%0b exp=0", i, carryout); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL logic%0d_ovf got=%0b exp=0", i, overflow); end
    end
  endtask

  task automatic test_start_during_run();
    int lat;
    @(negedge clock);
    A = 32'h5; B = 32'h3; control = ALU_ADD; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 2) begin
        total++; if (out !== 32'h0FF0_0FF0) begin bad++; $display("FAIL busy_prev_hold got=%h exp=0ff00ff0", out); end
      end
      if (lat == 4) begin A = 32'd100; B = 32'd200; control = ALU_SUB; start = 1'b1; end
      if (lat == 8) start = 1'b0;
      @(negedge clock);
      lat++;
    end
    total++; if (lat != 33)      begin bad++; $display("FAIL busy_ignore_latency got=%0d exp=33", lat); end
    total++; if (out !== 32'h8)  begin bad++; $display("FAIL busy_ignore_out got=%h exp=00000008", out); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clock);
    A = 32'd10; B = 32'd20; control = ALU_ADD; start = 1'b1;
    @(negedge clock);
    A = 32'd50; B = 32'd8; control = ALU_SUB;   // start stays high
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin @(negedge clock); lat++; end
    total++; if (lat != 33)      begin bad++; $display("FAIL b2b_first_latency got=%0d exp=33", lat); end
    total++; if (out !== 32'd30) begin bad++; $display("FAIL b2b_first_out got=%h exp=0000001e", out); end
    @(negedge clock);
    start = 1'b0;
    total++; if (busy !== 1'b1)  begin bad++; $display("FAIL b2b_no_bubble got=%0b exp=1", busy); end
    total++; if (out !== 32'd30) begin bad++; $display("FAIL b2b_hold got=%h exp=0000001e", out); end
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin @(negedge clock); lat++; end
    total++; if (lat != 33)         begin bad++; $display("FAIL b2b_second_latency got=%0d exp=33", lat); end
    total++; if (out !== 32'd42)    begin bad++; $display("FAIL b2b_second_out got=%h exp=0000002a", out); end
    total++; if (carryout !== 1'b1) begin bad++; $display("FAIL b2b_second_cout got=%0b exp=1", carryout); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_second_ovf got=%0b exp=0", overflow); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    @(negedge clock);
    A = 32'd9; B = 32'd9; control = ALU_ADD; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    total++; if (busy !== 1'b1)  begin bad++; $display("FAIL rstmid_pre_busy got=%0b exp=1", busy); end
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL rstmid_done got=%0b exp=0", done); end
    total++; if (out !== '0)        begin bad++; $display("FAIL rstmid_out got=%h exp=0", out); end
    total++; if (zero !== 1'b1)     begin bad++; $display("FAIL rstmid_zero got=%0b exp=1", zero); end
    total++; if (carryout !== 1'b0) begin bad++; $display("FAIL rstmid_cout got=%0b exp=0", carryout); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
    run_op(32'd1, 32'd1, ALU_ADD, lat, bc);
    total++; if (lat != 33)     begin bad++; $display("FAIL rstmid_next_latency got=%0d exp=33", lat); end
    total++; if (out !== 32'd2) begin bad++; $display("FAIL rstmid_next_out got=%h exp=00000002", out); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_add_wrap();
    test_logic();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
